key_debounce: RTL and testbench

Input conditioner for the board's active-low push buttons. It samples the raw `KEY` pin into `CLOCK_50` and rejects contact bounce. It then provides three things to the LED blinker and similar consumers downstream: a clean level, single-cycle press/release strobes, and a press-toggled mode bit. Consumers use these instead of reading the raw pin directly.

---
 rtl/key_debounce.sv | 101 ++++++++++
 tb/tb_key_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer plus a debounce FSM that
// produces a clean active-low level, press/release strobes and a press-toggled mode bit.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic KEY,
    output logic KEY_DB,
    output logic PRESS,
    output logic RELEASE,
    output logic TOGGLE
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          s1;
    logic          s2;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            state   <= RELEASED;
            count   <= '0;
            KEY_DB  <= 1'b1;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            TOGGLE  <= 1'b0;
        end else begin
            s1      <= KEY;
            s2      <= s1;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;

            unique case (state)
                RELEASED: begin
                    if (!s2) begin
                        count <= ONE;
                        state <= ARM_PRESS;
                    end else begin
                        count <= '0;
                    end
                end
                // A single opposite sample drops back to the settled state,
                // so acceptance always needs an unbroken run of new samples.
                ARM_PRESS: begin
                    if (s2) begin
                        count <= '0;
                        state <= RELEASED;
                    end else if (count == LAST) begin
                        count  <= '0;
                        state  <= PRESSED;
                        KEY_DB <= 1'b0;
                        PRESS  <= 1'b1;
                        TOGGLE <= ~TOGGLE;
                    end else begin
                        count <= count + ONE;
                    end
                end
                PRESSED: begin
                    if (s2) begin
                        count <= ONE;
                        state <= ARM_RELEASE;
                    end else begin
                        count <= '0;
                    end
                end
                ARM_RELEASE: begin
                    if (!s2) begin
                        count <= '0;
                        state <= PRESSED;
                    end else if (count == LAST) begin
                        count   <= '0;
                        state   <= RELEASED;
                        KEY_DB  <= 1'b1;
                        RELEASE <= 1'b1;
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8: reset, clean press,
// bounce, glitch rejection, toggle sequence and reset during arming.
module tb_key_debounce;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    logic KEY      = 1'b1;
    logic KEY_DB;
    logic PRESS;
    logic RELEASE;
    logic TOGGLE;

    int checks = 0;
    int errors = 0;
    int press_seen = 0;
    int release_seen = 0;
    int both_seen = 0;

    key_debounce #(.DEBOUNCE_CYCLES(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY      (KEY),
        .KEY_DB   (KEY_DB),
        .PRESS    (PRESS),
        .RELEASE  (RELEASE),
        .TOGGLE   (TOGGLE)
    );

    always #2 CLOCK_50 = ~CLOCK_50;

    // Strobe tally, sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (PRESS === 1'b1)   press_seen++;
        if (RELEASE === 1'b1) release_seen++;
        if (PRESS === 1'b1 && RELEASE === 1'b1) both_seen++;
    end

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Edges counted from the first edge after the call (that edge is n=1);
    // returns limit+1 if the strobe never appears.
    task automatic wait_strobe(input bit rel, input int limit, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < limit) begin
            tick();
            n++;
            if ((rel ? RELEASE : PRESS) === 1'b1) found = 1'b1;
        end
        if (!found) n = limit + 1;
    endtask

    initial begin
        int n;
        int p0;
        int r0;

        // 1. Reset held with key pressed
        RESET = 1'b1;
        KEY   = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_val("rst_key_db",  int'(KEY_DB),  1);
            check_val("rst_press",   int'(PRESS),   0);
            check_val("rst_release", int'(RELEASE), 0);
            check_val("rst_toggle",  int'(TOGGLE),  0);
        end
        RESET = 1'b0;
        wait_strobe(1'b0, 20, n);
        check_val("rst_held_press_edge", n, 10);
        check_val("rst_held_key_db", int'(KEY_DB), 0);
        check_val("rst_held_toggle", int'(TOGGLE), 1);
        tick();
        check_val("press_width", int'(PRESS), 0);
        KEY = 1'b1;
        wait_strobe(1'b1, 20, n);
        check_val("rst_held_release_edge", n, 10);
        check_val("rst_held_release_key_db", int'(KEY_DB), 1);
        tick();
        check_val("release_width", int'(RELEASE), 0);

        // 2. Clean press from a fresh reset
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        check_val("clean_toggle_before", int'(TOGGLE), 0);
        r0 = release_seen;
        KEY = 1'b0;
        wait_strobe(1'b0, 20, n);
        check_val("clean_press_edge", n, 10);
        check_val("clean_key_db", int'(KEY_DB), 0);
        check_val("clean_toggle", int'(TOGGLE), 1);
        tick();
        check_val("clean_press_width", int'(PRESS), 0);
        check_val("clean_no_release", release_seen - r0, 0);

        // 3. Bounce while released-going, then settle high
        p0 = press_seen;
        r0 = release_seen;
        for (int unsigned i = 0; i < 40; i++) begin
            KEY = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        check_val("bounce_no_press", press_seen - p0, 0);
        check_val("bounce_no_release", release_seen - r0, 0);
        check_val("bounce_key_db", int'(KEY_DB), 0);
        KEY = 1'b1;
        wait_strobe(1'b1, 20, n);
        check_val("bounce_release_edge", n, 10);
        check_val("bounce_key_db_after", int'(KEY_DB), 1);
        tick();
        check_val("bounce_one_release", release_seen - r0, 1);

        // 4. Glitch rejection: 7-edge low pulse, then 8-edge low pulse
        p0 = press_seen;
        for (int unsigned i = 0; i < 27; i++) begin
            KEY = (i < 7) ? 1'b0 : 1'b1;
            tick();
        end
        check_val("glitch7_no_press", press_seen - p0, 0);
        check_val("glitch7_key_db", int'(KEY_DB), 1);
        p0 = press_seen;
        r0 = release_seen;
        for (int unsigned i = 0; i < 30; i++) begin
            KEY = (i < 8) ? 1'b0 : 1'b1;
            tick();
        end
        check_val("glitch8_one_press", press_seen - p0, 1);
        check_val("glitch8_one_release", release_seen - r0, 1);
        check_val("glitch8_key_db", int'(KEY_DB), 1);

        // 5. Three press/release pairs
        check_val("seq_toggle_before", int'(TOGGLE), 0);
        p0 = press_seen;
        r0 = release_seen;
        for (int unsigned i = 0; i < 3; i++) begin
            KEY = 1'b0;
            wait_strobe(1'b0, 20, n);
            check_val("seq_press_edge", n, 10);
            KEY = 1'b1;
            wait_strobe(1'b1, 20, n);
            check_val("seq_release_edge", n, 10);
        end
        tick();
        check_val("seq_presses", press_seen - p0, 3);
        check_val("seq_releases", release_seen - r0, 3);
        check_val("seq_toggle", int'(TOGGLE), 1);

        // 6. Reset while arming a press (count reaches 5 after 7 edges)
        p0 = press_seen;
        KEY = 1'b0;
        repeat (7) tick();
        RESET = 1'b1;
        tick();
        check_val("midarm_no_press", press_seen - p0, 0);
        check_val("midarm_key_db", int'(KEY_DB), 1);
        check_val("midarm_toggle", int'(TOGGLE), 0);
        RESET = 1'b0;
        wait_strobe(1'b0, 20, n);
        check_val("midarm_press_edge", n, 10);
        check_val("midarm_toggle_after", int'(TOGGLE), 1);
        check_val("midarm_key_db_after", int'(KEY_DB), 0);
        tick();
        check_val("midarm_one_press", press_seen - p0, 1);

        check_val("never_both_strobes", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
